// File: rtl/mult_unit.sv
// Iterative shift-add multiplier with HI/LO pair for mult/multu.
// One partial product per cycle; busy stalls the pipe while running.
module mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic             rd_hi,
   output logic [WIDTH-1:0] hilo_rd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t state, nstate;

   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] sum;
   logic [2*WIDTH-1:0] fin;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic               neg;
   logic               last;

   // Magnitudes: the most negative value maps onto itself, read as unsigned
   assign abs_a = (signed_op && srca[WIDTH-1]) ? ~srca + 1'b1 : srca;
   assign abs_b = (signed_op && srcb[WIDTH-1]) ? ~srcb + 1'b1 : srcb;

   assign sum  = acc + (mplier[0] ? mcand : '0);
   assign fin  = neg ? ~sum + 1'b1 : sum;
   assign last = (state == RUN) && (cnt == LAST);

   assign busy    = ((state == IDLE) && start) || (state == RUN);
   assign hilo_rd = rd_hi ? hi : lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE: if (start) nstate = RUN;
         RUN:  if (last)  nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         neg    <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {{WIDTH{1'b0}}, abs_a};
                  mplier <= abs_b;
                  acc    <= '0;
                  cnt    <= '0;
                  neg    <= signed_op & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
               end else begin
                  if (mthi) hi <= srca;
                  if (mtlo) lo <= srca;
               end
            end
            RUN: begin
               acc    <= sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  hi   <= fin[2*WIDTH-1:WIDTH];
                  lo   <= fin[WIDTH-1:0];
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_unit.sv
// Randomized self-checking bench for mult_unit.
// Products come from plain 64-bit arithmetic on the operands.
module tb_mult_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        signed_op;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        mthi;
   logic        mtlo;
   logic        rd_hi;
   logic [31:0] hilo_rd;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_chk;
   int n_fail;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mult_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .signed_op (signed_op),
      .srca      (srca),
      .srcb      (srcb),
      .mthi      (mthi),
      .mtlo      (mtlo),
      .rd_hi     (rd_hi),
      .hilo_rd   (hilo_rd),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic s);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      if (s) begin
         sa = $signed({{32{a[31]}}, a});
         sb = $signed({{32{b[31]}}, b});
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // Launch in the current cycle; returns in the done cycle.
   task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic mv,
                          input int run_mtlo, input int run_start);
      logic [63:0] p;
      int k;
      int nb;
      p = ref_mul(a, b, s);
      start = 1'b1;
      signed_op = s;
      srca = a;
      srcb = b;
      mtlo = mv;
      #1;
      check("busy_c0", 64'(busy), 64'd1);
      edge1();
      start = 1'b0;
      mtlo = 1'b0;
      srca = $urandom;
      srcb = $urandom;
      nb = 1;
      k = 1;
      while (!done && k < 100) begin
         if (busy) nb++;
         mtlo = (k == run_mtlo);
         start = (k == run_start);
         edge1();
         k++;
      end
      start = 1'b0;
      mtlo = 1'b0;
      #1;
      m_hi = p[63:32];
      m_lo = p[31:0];
      check("done_lat", 64'(k), 64'd33);
      check("busy_cnt", 64'(nb), 64'd33);
      check("busy_off", 64'(busy), 64'd0);
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      rd_hi = 1'b1;
      #1;
      check("rd_hi", 64'(hilo_rd), 64'(m_hi));
      rd_hi = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      logic [31:0] ra;
      logic [31:0] rb;
      int nd;
      n_chk = 0;
      n_fail = 0;
      m_hi = '0;
      m_lo = '0;
      rst_n = 1'b0;
      start = 1'b0;
      signed_op = 1'b0;
      srca = '0;
      srcb = '0;
      mthi = 1'b0;
      mtlo = 1'b0;
      rd_hi = 1'b0;
      #3;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      start = 1'b1;
      #1;
      check("rst_busy_start", 64'(busy), 64'd1);
      start = 1'b0;
      edge1();
      edge1();
      rst_n = 1'b1;
      edge1();

      do_mult(32'd7, 32'd6, 1'b0, 1'b0, 0, 0);
      check("lo_7x6", 64'(lo), 64'h2A);
      edge1();
      do_mult(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0, 0, 0);
      edge1();
      do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 0);
      check("hi_ffff", 64'(hi), 64'hFFFFFFFE);
      edge1();
      do_mult(32'h80000000, 32'h80000000, 1'b1, 1'b0, 0, 0);
      check("hi_min2", 64'(hi), 64'h40000000);
      edge1();
      do_mult(32'h80000000, 32'd1, 1'b1, 1'b0, 0, 0);
      check("lo_min1", 64'(lo), 64'h80000000);
      edge1();

      // Reset mid-run
      start = 1'b1;
      signed_op = 1'b0;
      srca = 32'd9;
      srcb = 32'd9;
      edge1();
      start = 1'b0;
      repeat (9) edge1();
      rst_n = 1'b0;
      #1;
      m_hi = '0;
      m_lo = '0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      edge1();
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) nd++;
         edge1();
      end
      check("abort_nodone", 64'(nd), 64'd0);
      do_mult(32'd9, 32'd9, 1'b0, 1'b0, 0, 0);
      check("lo_9x9", 64'(lo), 64'h51);
      edge1();

      // Moves
      srca = 32'h1234;
      mthi = 1'b1;
      edge1();
      mthi = 1'b0;
      m_hi = 32'h1234;
      rd_hi = 1'b1;
      #1;
      check("mthi_rd", 64'(hilo_rd), 64'(m_hi));
      rd_hi = 1'b0;
      v = $urandom;
      srca = v;
      mthi = 1'b1;
      mtlo = 1'b1;
      edge1();
      mthi = 1'b0;
      mtlo = 1'b0;
      m_hi = v;
      m_lo = v;
      check("mv_both_hi", 64'(hi), 64'(m_hi));
      check("mv_both_lo", 64'(lo), 64'(m_lo));

      do_mult(32'd11, 32'd13, 1'b0, 1'b1, 0, 0);
      edge1();
      do_mult(32'hABCD, 32'h77, 1'b1, 1'b0, 3, 0);
      edge1();
      do_mult(32'd100, 32'hFFFFFF9C, 1'b1, 1'b0, 0, 5);
      edge1();
      check("single_done", 64'(done), 64'd0);

      // Back-to-back
      do_mult(32'd5, 32'd5, 1'b0, 1'b0, 0, 0);
      do_mult(32'd2, 32'd3, 1'b0, 1'b0, 0, 0);
      check("lo_b2b", 64'(lo), 64'd6);
      edge1();

      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 1) ra = 32'h80000000;
         if (i % 5 == 2) rb = 32'hFFFFFFFF;
         do_mult(ra, rb, 1'(($urandom) & 1), 1'b0, 0, 0);
         if (($urandom & 1) != 0) edge1();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative shift-add multiplier for the MIPS `mult`/`multu` instructions, with the architectural HI/LO register pair. It sits in the Execute stage beside the ALU and takes its operands from the forwarded ALU source buses. Its `busy` output drives the hazard unit's `MultFinish` input, which stalls Fetch, Decode and Execute while a product is being formed. `mfhi`/`mflo` read HI/LO through `hilo_rd`; `mthi`/`mtlo` write them.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits wide.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: multiply request in the Execute stage. Sampled only in IDLE.
- `signed_op` input 1: 1 = `mult` (two's complement), 0 = `multu`. Sampled with `start`.
- `srca` input WIDTH: multiplicand, forwarded ALU source A.
- `srcb` input WIDTH: multiplier, forwarded ALU source B.
- `mthi` input 1: write `srca` into HI.
- `mtlo` input 1: write `srca` into LO.
- `rd_hi` input 1: `hilo_rd` selects HI when 1, LO when 0.
- `hilo_rd` output WIDTH: combinational read of the selected register, for `mfhi`/`mflo`.
- `busy` output 1: stall request to the hazard unit (its `MultFinish`). Combinational.
- `done` output 1: registered one-cycle pulse; HI/LO hold the new product in this cycle.
- `hi`, `lo` outputs WIDTH: direct register outputs, for debug and verification.

## Operation
- Two states, IDLE and RUN. Internal registers:
  - `cnt`: iteration counter, $clog2(WIDTH)+1 bits.
  - `mcand`: 2·WIDTH-bit shifting multiplicand.
  - `mplier`: WIDTH-bit shifting multiplier.
  - `acc`: 2·WIDTH-bit accumulator.
  - `neg`: result-negate flag.
- IDLE with `start`=1:
  - Unsigned, or signed with a non-negative operand: load the operand value unchanged.
  - Signed with a negative operand: load its magnitude, i.e. (~x+1) truncated to WIDTH. 0x80000000 therefore gives magnitude 0x80000000, treated as unsigned.
  - `mcand` = zero-extended |`srca|`, `mplier` = |`srcb`|, `acc` = 0, `cnt` = 0.
  - `neg` = `signed_op` & (`srca`[MSB] ^ `srcb`[MSB]).
  - Go to RUN.
- RUN, every cycle:
  - If `mplier`[0] = 1, add `mcand` to `acc`.
  - Shift `mcand` left 1, shift `mplier` right 1, increment `cnt`.
- RUN, last iteration (`cnt` = WIDTH-1):
  - Take the final accumulator value, including this cycle's add.
  - Write {HI,LO} = `neg` ? (~final+1) : final. All arithmetic is modulo 2^(2·WIDTH).
  - Set `done` for the next cycle and go to IDLE.
- `busy` = (IDLE & `start`) | RUN.
- `start` in RUN is ignored. The hazard stall holds Execute, so the requester re-presents nothing.
- `mthi`/`mtlo`:
  - Take effect only in IDLE with `start`=0.
  - If `start`=1 in the same cycle, `start` wins and the move is dropped.
  - Ignored in RUN.
  - `mthi` and `mtlo` together write both registers with `srca`.
- `hilo_rd` always shows the current HI/LO register contents. It never shows partial products.

## Timing
- Reset (`rst_n`=0, asynchronous): state = IDLE, `cnt`=0, `acc`/`mcand`/`mplier`=0, `neg`=0, HI=LO=0, `done`=0. `busy` then follows `start` combinationally.
- Cycle 0: `start` high in IDLE, `busy`=1 in the same cycle. Operands are captured at the end of cycle 0.
- Cycles 1..WIDTH: RUN, `busy`=1. HI/LO are written at the end of cycle WIDTH.
- Cycle WIDTH+1: IDLE, `busy`=0, `done`=1, HI/LO valid. Total stall is WIDTH+1 cycles (33 for WIDTH=32).
- `start` held high in cycle WIDTH+1 launches a new multiply; this is back-to-back operation.
- `rst_n` falling mid-RUN: abort immediately. `busy` drops asynchronously, no HI/LO write, `done` stays 0.
- `mthi`/`mtlo` update the register at the clock edge. `hilo_rd` reflects the new value the following cycle.

## Test plan
- Unsigned 7×6 (`multu`, `srca`=7, `srcb`=6) -> `busy` high for 33 cycles; cycle 33 `done`=1, HI=0x00000000, LO=0x0000002A.
- Signed −3×5 (`mult`, `srca`=0xFFFFFFFD, `srcb`=5) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Corners:
  - `multu` 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
  - `mult` 0x80000000×0x80000000 -> HI=0x40000000, LO=0x00000000.
  - `mult` 0x80000000×1 -> HI=0xFFFFFFFF, LO=0x80000000.
- Reset mid-operation: start 9×9, drop `rst_n` at cycle 10 -> `busy`=0 immediately, HI=LO=0, no `done`. A fresh start after reset gives LO=0x51.
- Moves and conflicts:
  - `mthi` with `srca`=0x1234 in IDLE -> `hilo_rd` with `rd_hi`=1 reads 0x1234 next cycle.
  - `mtlo` asserted together with `start` -> LO holds the product, not `srca`.
  - `mtlo` during RUN -> ignored.
- Back-to-back and ignored start:
  - `start` pulsed at cycle 5 of RUN -> no effect; a single `done` at cycle 33.
  - `start` at cycle 33 (2×3) -> second `done` at cycle 66, LO=6.
